fb_write_arb: RTL and testbench
===============================

# fb_write_arb

Write-port arbiter and clear sequencer for the video display processor's framebuffer. It shares the single framebuffer write port (`fb_wadr`/`fb_we`/`fb_d`) between two pixel writers, a host path A and a drawing path B, using round-robin arbitration. A built-in clear engine can take the port exclusively to fill the whole buffer with one colour. All writes are gated by a write-window input so that pixel updates can be confined to blanking.

## Interface
- `AW`, 16: framebuffer address width.
- `DW`, 24: pixel width (8:8:8 RGB).
- `DEPTH`, 65536: number of framebuffer words swept by a clear; must satisfy 1 ≤ DEPTH ≤ 2^AW.

Ports:
- `CLOCK_50` in 1: sole clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write window; when 0, no write is accepted or issued.
- `a_valid` in 1, `a_ready` out 1, `a_adr` in AW, `a_d` in DW: requester A write request.
- `b_valid` in 1, `b_ready` out 1, `b_adr` in AW, `b_d` in DW: requester B write request.
- `clr_start` in 1: one-cycle pulse that requests a full-buffer clear.
- `clr_color` in DW: fill colour; sampled only on an accepted `clr_start`.
- `clr_busy` out 1: a clear is in progress.
- `clr_done` out 1: one-cycle pulse that accompanies the final clear write.
- `fb_wadr` out AW, `fb_we` out 1, `fb_d` out DW: registered framebuffer write port.

## Operation
- There are two states, ARB and CLEAR. Reset enters ARB with the clear counter at 0, `last_grant` at B (so A wins the first tie), and the latched colour at 0.
- ARB: `a_ready` and `b_ready` are combinational. At most one is high in any cycle, and neither is high unless `wr_en`=1 and `clr_start`=0.
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not `last_grant`.
- A transfer occurs when `x_valid` and `x_ready` are both high. On a transfer, the block registers `x_adr` and `x_d` onto `fb_wadr` and `fb_d`, and `last_grant` is set to x.
- A requester must hold its address and data stable while `valid`=1 and `ready`=0, and must not drop `valid` before the transfer completes.
- `clr_start`=1 in ARB is accepted regardless of `wr_en`:
  - `clr_color` is latched and the counter is cleared to 0.
  - The next state is CLEAR.
  - `clr_start` takes priority over same-cycle requests; both readies are 0 in that cycle.
- CLEAR:
  - Both readies are held at 0.
  - Each cycle with `wr_en`=1 issues one write of the latched colour at the counter address, then increments the counter.
  - Cycles with `wr_en`=0 pause the sweep: no write is issued and the counter holds.
  - After the write to `DEPTH-1` is issued, the next state is ARB.
- `clr_start` while in CLEAR is ignored: no restart and no colour change.
- `fb_we` is 0 in every cycle without an issued write. In those cycles `fb_wadr` and `fb_d` hold their last values.
- The counter is AW+1 bits wide, so DEPTH=2^AW terminates without wrapping. The address driven out is the low AW bits.
- Reset asserted mid-operation (including mid-clear) abandons everything immediately. No partial-state resumption occurs after release.

## Timing
- Reset values: `fb_we`=0, `fb_wadr`=0, `fb_d`=0, `clr_busy`=0, `clr_done`=0, `a_ready`=0, `b_ready`=0.
- Write latency: a transfer in cycle N gives `fb_we`=1 with its address and data in cycle N+1.
- Throughput: one write per cycle. Back-to-back transfers alternate A/B when both requesters are continuously valid.
- `clr_start` accepted in cycle N:
  - `clr_busy`=1 from N+1.
  - The first clear write (address 0) appears on the port in N+2 if `wr_en`=1 in N+1.
- Final clear write on the port in cycle M:
  - `clr_done`=1 in M only.
  - `clr_busy` falls to 0 in M+1.
  - Readies may assert in M.
- A clear with continuous `wr_en` occupies the port for DEPTH+1 cycles from acceptance to `clr_done`.

## Test plan
- Reset then single write:
  - Stimulus: `rst` low 3 cycles, then `a_valid`=1, `a_adr`=0x0010, `a_d`=0xFF0000, `wr_en`=1.
  - Response: `a_ready`=1 in the same cycle. Next cycle `fb_we`=1, `fb_wadr`=0x0010, `fb_d`=0xFF0000. All outputs are 0 during reset.
- Round-robin:
  - Stimulus: A and B both valid continuously for 6 cycles, `wr_en`=1.
  - Response: grants in the order A,B,A,B,A,B; `fb_wadr` alternates between the A and B addresses, one write per cycle.
- Write window:
  - Stimulus: A valid with `wr_en`=0 for 4 cycles, then `wr_en`=1.
  - Response: `a_ready`=0 and `fb_we`=0 for the 4 cycles; the write is issued one cycle after `wr_en` rises.
- Clear:
  - Stimulus: `DEPTH`=8, `clr_start` with `clr_color`=0x00FF00 while A is valid in the same cycle.
  - Response: A is not readied. Addresses 0..7 are written with 0x00FF00 on consecutive cycles. `clr_done` is high with address 7. A is granted afterwards.
- Paused clear:
  - Stimulus: `DEPTH`=8, `wr_en` dropped for 3 cycles after address 3, and a second `clr_start` during the clear.
  - Response: `fb_we`=0 for 3 cycles, the sweep resumes at address 4, the second start is ignored, and exactly 8 writes are issued.
- Reset mid-clear:
  - Stimulus: `rst` low at address 5.
  - Response: `fb_we`, `clr_busy`, and `clr_done` go to 0 immediately. After release the block is in ARB and a new clear restarts at address 0.

Source files
------------

// File: rtl/fb_write_arb.sv
// Framebuffer write-port arbiter: round-robin between host (A) and draw (B) writers,
// plus a clear engine that sweeps the whole buffer with one colour.
module fb_write_arb #(
   parameter int unsigned AW    = 16,
   parameter int unsigned DW    = 24,
   parameter int unsigned DEPTH = 65536
) (
   input  logic          CLOCK_50,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_adr,
   input  logic [DW-1:0] a_d,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_adr,
   input  logic [DW-1:0] b_d,
   input  logic          clr_start,
   input  logic [DW-1:0] clr_color,
   output logic          clr_busy,
   output logic          clr_done,
   output logic [AW-1:0] fb_wadr,
   output logic          fb_we,
   output logic [DW-1:0] fb_d
);

   typedef enum logic [0:0] {StArb, StClear} state_e;

   // Counter is one bit wider than the address so DEPTH == 2^AW ends without wrapping.
   localparam logic [AW:0] LastIdx = (AW+1)'(DEPTH - 1);

   state_e        r_state;
   logic          r_last_b;
   logic [AW:0]   r_cnt;
   logic [DW-1:0] r_color;
   logic [AW-1:0] r_fb_wadr;
   logic          r_fb_we;
   logic [DW-1:0] r_fb_d;
   logic          r_clr_busy;
   logic          r_clr_done;

   logic w_arb_open;
   logic w_grant_a;
   logic w_grant_b;

   // Readies stay low while reset is held so nothing looks accepted during reset.
   assign w_arb_open = rst && (r_state == StArb) && wr_en && !clr_start;
   assign w_grant_a  = w_arb_open && a_valid && (!b_valid || r_last_b);
   assign w_grant_b  = w_arb_open && b_valid && (!a_valid || !r_last_b);

   assign a_ready  = w_grant_a;
   assign b_ready  = w_grant_b;
   assign clr_busy = r_clr_busy;
   assign clr_done = r_clr_done;
   assign fb_wadr  = r_fb_wadr;
   assign fb_we    = r_fb_we;
   assign fb_d     = r_fb_d;

   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) begin
         r_state    <= StArb;
         r_last_b   <= 1'b1;
         r_cnt      <= '0;
         r_color    <= '0;
         r_fb_wadr  <= '0;
         r_fb_we    <= 1'b0;
         r_fb_d     <= '0;
         r_clr_busy <= 1'b0;
         r_clr_done <= 1'b0;
      end else begin
         r_fb_we    <= 1'b0;
         r_clr_done <= 1'b0;
         case (r_state)
            StArb: begin
               // Busy stays up through the cycle carrying the final clear write.
               r_clr_busy <= 1'b0;
               if (clr_start) begin
                  r_state    <= StClear;
                  r_color    <= clr_color;
                  r_cnt      <= '0;
                  r_clr_busy <= 1'b1;
               end else if (w_grant_a) begin
                  r_fb_we   <= 1'b1;
                  r_fb_wadr <= a_adr;
                  r_fb_d    <= a_d;
                  r_last_b  <= 1'b0;
               end else if (w_grant_b) begin
                  r_fb_we   <= 1'b1;
                  r_fb_wadr <= b_adr;
                  r_fb_d    <= b_d;
                  r_last_b  <= 1'b1;
               end
            end
            StClear: begin
               if (wr_en) begin
                  r_fb_we   <= 1'b1;
                  r_fb_wadr <= r_cnt[AW-1:0];
                  r_fb_d    <= r_color;
                  r_cnt     <= r_cnt + 1'b1;
                  if (r_cnt == LastIdx) begin
                     r_state    <= StArb;
                     r_clr_done <= 1'b1;
                  end
               end
            end
            default: r_state <= StArb;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_arb.sv
// Directed self-checking bench for fb_write_arb with an 8-word clear sweep.
module tb_fb_write_arb;

   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 24;
   localparam int unsigned DEPTH = 8;

   logic          CLOCK_50;
   logic          rst;
   logic          wr_en;
   logic          a_valid, a_ready;
   logic [AW-1:0] a_adr;
   logic [DW-1:0] a_d;
   logic          b_valid, b_ready;
   logic [AW-1:0] b_adr;
   logic [DW-1:0] b_d;
   logic          clr_start;
   logic [DW-1:0] clr_color;
   logic          clr_busy, clr_done;
   logic [AW-1:0] fb_wadr;
   logic          fb_we;
   logic [DW-1:0] fb_d;

   int n_tests = 0;
   int n_fail  = 0;
   int wcount;
   logic exp_we;

   fb_write_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .CLOCK_50  (CLOCK_50),
      .rst       (rst),
      .wr_en     (wr_en),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_adr     (a_adr),
      .a_d       (a_d),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_adr     (b_adr),
      .b_d       (b_d),
      .clr_start (clr_start),
      .clr_color (clr_color),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .fb_wadr   (fb_wadr),
      .fb_we     (fb_we),
      .fb_d      (fb_d)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic mid();
      @(negedge CLOCK_50);
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b1;
      a_valid = 1'b1; a_adr = 16'h0010; a_d = 24'hFF0000;
      b_valid = 1'b1; b_adr = '0; b_d = '0;
      clr_start = 1'b0; clr_color = '0;

      // Reset: every output low even with requests pending
      repeat (3) begin
         mid();
         chk("rst_fb_we", fb_we, 0);
         chk("rst_fb_wadr", fb_wadr, 0);
         chk("rst_fb_d", fb_d, 0);
         chk("rst_busy", clr_busy, 0);
         chk("rst_done", clr_done, 0);
         chk("rst_a_ready", a_ready, 0);
         chk("rst_b_ready", b_ready, 0);
      end

      // Single A write
      next_cycle(); rst = 1'b1; b_valid = 1'b0;
      mid();
      chk("single_a_ready", a_ready, 1);
      chk("single_b_ready", b_ready, 0);

      // B-only write so last grant is B before round-robin
      next_cycle(); a_valid = 1'b0; b_valid = 1'b1; b_adr = 16'h0020; b_d = 24'h0000FF;
      mid();
      chk("single_we", fb_we, 1);
      chk("single_wadr", fb_wadr, 32'h0010);
      chk("single_d", fb_d, 32'hFF0000);
      chk("bonly_b_ready", b_ready, 1);
      chk("bonly_a_ready", a_ready, 0);

      // Round-robin, both continuously valid: A,B,A,B,A,B
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         a_valid = 1'b1; a_adr = 16'h0100; a_d = 24'h111111;
         b_valid = 1'b1; b_adr = 16'h0200; b_d = 24'h222222;
         mid();
         chk("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
         chk("rr_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
         chk("rr_we", fb_we, 1);
         chk("rr_wadr", fb_wadr, (i == 0) ? 32'h20 : ((i % 2 == 1) ? 32'h100 : 32'h200));
      end
      next_cycle(); a_valid = 1'b0; b_valid = 1'b0;
      mid();
      chk("rr_last_we", fb_we, 1);
      chk("rr_last_wadr", fb_wadr, 32'h200);
      chk("rr_last_d", fb_d, 32'h222222);

      // Write window closed for 4 cycles
      for (int i = 0; i < 4; i++) begin
         next_cycle(); wr_en = 1'b0; a_valid = 1'b1; a_adr = 16'h0030; a_d = 24'h123456;
         mid();
         chk("win_a_ready", a_ready, 0);
         chk("win_we", fb_we, 0);
         chk("win_hold_wadr", fb_wadr, 32'h200);
         chk("win_hold_d", fb_d, 32'h222222);
      end
      next_cycle(); wr_en = 1'b1;
      mid();
      chk("win_open_a_ready", a_ready, 1);
      chk("win_open_we", fb_we, 0);

      // Clear with a simultaneous A request
      next_cycle(); clr_start = 1'b1; clr_color = 24'h00FF00; a_adr = 16'h0040; a_d = 24'hABCDEF;
      mid();
      chk("clr_acc_a_ready", a_ready, 0);
      chk("clr_acc_b_ready", b_ready, 0);
      chk("win_write_we", fb_we, 1);
      chk("win_write_wadr", fb_wadr, 32'h30);
      chk("win_write_d", fb_d, 32'h123456);
      chk("clr_acc_busy", clr_busy, 0);
      next_cycle(); clr_start = 1'b0; clr_color = '0;
      mid();
      chk("clr_n1_a_ready", a_ready, 0);
      chk("clr_n1_we", fb_we, 0);
      chk("clr_n1_busy", clr_busy, 1);
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         mid();
         chk("clr_we", fb_we, 1);
         chk("clr_wadr", fb_wadr, k);
         chk("clr_d", fb_d, 32'h00FF00);
         chk("clr_done", clr_done, (k == 7) ? 1 : 0);
         chk("clr_busy", clr_busy, 1);
         chk("clr_a_ready", a_ready, (k == 7) ? 1 : 0);
      end
      next_cycle(); a_valid = 1'b0;
      mid();
      chk("clr_after_busy", clr_busy, 0);
      chk("clr_after_done", clr_done, 0);
      chk("clr_after_we", fb_we, 1);
      chk("clr_after_wadr", fb_wadr, 32'h40);
      chk("clr_after_d", fb_d, 32'hABCDEF);

      // Paused clear with an ignored second start
      next_cycle(); clr_start = 1'b1; clr_color = 24'h0000AA;
      mid();
      chk("pause_acc_busy", clr_busy, 0);
      wcount = 0;
      for (int c = 1; c <= 14; c++) begin
         next_cycle();
         clr_start = (c == 3);
         clr_color = (c == 3) ? 24'hFFFFFF : 24'h0;
         wr_en = !(c >= 5 && c <= 7);
         mid();
         exp_we = (c >= 2 && c <= 5) || (c >= 9 && c <= 12);
         chk("pause_we", fb_we, exp_we);
         if (exp_we) begin
            chk("pause_wadr", fb_wadr, (c <= 5) ? c - 2 : c - 5);
            chk("pause_d", fb_d, 32'h0000AA);
         end
         chk("pause_done", clr_done, (c == 12) ? 1 : 0);
         chk("pause_busy", clr_busy, (c <= 12) ? 1 : 0);
         if (fb_we) wcount++;
      end
      chk("pause_write_count", wcount, 8);

      // Reset in the middle of a clear
      next_cycle(); clr_start = 1'b1; clr_color = 24'h333333; wr_en = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         next_cycle(); clr_start = 1'b0;
      end
      mid();
      chk("midrst_pre_we", fb_we, 1);
      chk("midrst_pre_wadr", fb_wadr, 32'h5);
      #2 rst = 1'b0;
      #1;
      chk("midrst_we", fb_we, 0);
      chk("midrst_busy", clr_busy, 0);
      chk("midrst_done", clr_done, 0);
      chk("midrst_wadr", fb_wadr, 0);
      next_cycle();
      next_cycle(); rst = 1'b1; a_valid = 1'b1; a_adr = 16'h0050; a_d = 24'h555555;
      mid();
      chk("postrst_a_ready", a_ready, 1);
      chk("postrst_busy", clr_busy, 0);
      next_cycle(); a_valid = 1'b0; clr_start = 1'b1; clr_color = 24'h444444;
      mid();
      chk("postrst_we", fb_we, 1);
      chk("postrst_wadr", fb_wadr, 32'h50);
      next_cycle(); clr_start = 1'b0;
      mid();
      chk("reclr_busy", clr_busy, 1);
      chk("reclr_n1_we", fb_we, 0);
      next_cycle();
      mid();
      chk("reclr_we0", fb_we, 1);
      chk("reclr_wadr0", fb_wadr, 0);
      chk("reclr_d0", fb_d, 32'h444444);
      next_cycle();
      mid();
      chk("reclr_wadr1", fb_wadr, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
